// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes an RV32I instruction plus its register read data
// into ALU operands and control, then holds the result in a main register
// backed by a one-entry skid register. in_ready depends only on registered
// state, so there is no combinational path from out_ready to in_ready.
module alu_issue_stage #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [width-1:0] in_pc,
    input  logic [width-1:0] in_rs1_data,
    input  logic [width-1:0] in_rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_a,
    output logic [width-1:0] out_b,
    output logic [3:0]       out_alu_control,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             out_is_branch,
    output logic             out_branch_invert,
    output logic             out_illegal
);

    // ALU operation codes. 0110 (NOR) exists in the ALU but is never issued.
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [width-1:0] a;
        logic [width-1:0] b;
        logic [3:0]       alu_control;
        logic [4:0]       rd;
        logic             reg_write;
        logic             is_branch;
        logic             branch_invert;
        logic             illegal;
    } entry_t;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [width-1:0] imm_i;
    logic [width-1:0] imm_s;
    logic [width-1:0] imm_u;
    logic [width-1:0] shamt;
    logic [3:0]       op_ctrl;
    logic             bad;
    entry_t           dec;

    entry_t main_q;
    entry_t skid_q;
    logic   main_valid;
    logic   skid_valid;
    logic   accept;
    logic   deliver;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = width'($signed(in_instr[31:20]));
    assign imm_s  = width'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_u  = width'($signed({in_instr[31:12], 12'b0}));
    assign shamt  = width'(in_instr[24:20]);

    // funct3 to ALU code, shared by register and immediate arithmetic
    always_comb begin
        op_ctrl = ALU_ADD;
        case (funct3)
            3'b000:  op_ctrl = ALU_ADD;
            3'b001:  op_ctrl = ALU_SLL;
            3'b010:  op_ctrl = ALU_SLT;
            3'b011:  op_ctrl = ALU_SLTU;
            3'b100:  op_ctrl = ALU_XOR;
            3'b101:  op_ctrl = ALU_SRL;
            3'b110:  op_ctrl = ALU_OR;
            default: op_ctrl = ALU_AND;
        endcase
    end

    // full instruction decode; any illegal encoding collapses to a zeroed ADD
    always_comb begin
        dec             = '0;
        dec.rd          = in_instr[11:7];
        dec.alu_control = ALU_ADD;
        bad             = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.a           = in_rs1_data;
                dec.b           = in_rs2_data;
                dec.reg_write   = 1'b1;
                dec.alu_control = op_ctrl;
                if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)      dec.alu_control = ALU_SUB;
                    else if (funct3 == 3'b101) dec.alu_control = ALU_SRA;
                    else                       bad = 1'b1;
                end else if (funct7 != F7_BASE) begin
                    bad = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.a           = in_rs1_data;
                dec.b           = imm_i;
                dec.reg_write   = 1'b1;
                dec.alu_control = op_ctrl;
                // only the shifts give funct7 a meaning; elsewhere it is immediate
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.b = shamt;
                    if (funct3 == 3'b101 && funct7 == F7_ALT) dec.alu_control = ALU_SRA;
                    else if (funct7 != F7_BASE)               bad = 1'b1;
                end
            end
            OPC_LOAD: begin
                dec.a         = in_rs1_data;
                dec.b         = imm_i;
                dec.reg_write = 1'b1;
            end
            OPC_STORE: begin
                dec.a = in_rs1_data;
                dec.b = imm_s;
            end
            OPC_BRANCH: begin
                dec.a             = in_rs1_data;
                dec.b             = in_rs2_data;
                dec.is_branch     = 1'b1;
                dec.branch_invert = funct3[0];
                case (funct3[2:1])
                    2'b00:   dec.alu_control = ALU_SUB;
                    2'b10:   dec.alu_control = ALU_SLT;
                    2'b11:   dec.alu_control = ALU_SLTU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec.b         = imm_u;
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a         = in_pc;
                dec.b         = imm_u;
                dec.reg_write = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec.a         = in_pc;
                dec.b         = width'(4);
                dec.reg_write = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec             = '0;
            dec.rd          = in_instr[11:7];
            dec.alu_control = ALU_ADD;
            dec.illegal     = 1'b1;
        end
    end

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign deliver  = main_valid & out_ready;

    // main/skid storage: skid drains into main first so order is preserved
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (deliver) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q <= dec;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end
        end
    end

    assign out_valid         = main_valid;
    assign out_a             = main_q.a;
    assign out_b             = main_q.b;
    assign out_alu_control   = main_q.alu_control;
    assign out_rd            = main_q.rd;
    assign out_reg_write     = main_q.reg_write;
    assign out_is_branch     = main_q.is_branch;
    assign out_branch_invert = main_q.branch_invert;
    assign out_illegal       = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: inputs change and outputs are sampled on the
// falling edge; expected entries are queued when an accept is due at the
// next rising edge and popped when a delivery is due.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
        logic        br;
        logic        inv;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_rs1_data = '0;
    logic [31:0] in_rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_alu_control;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_is_branch;
    logic        out_branch_invert;
    logic        out_illegal;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    alu_issue_stage #(.width(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_alu_control(out_alu_control),
        .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_is_branch(out_is_branch), .out_branch_invert(out_branch_invert),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic [31:0] a, logic [31:0] b, logic [3:0] ctrl,
                                logic [4:0] rd, logic rw, logic br, logic inv);
        exp_t e;
        e = '{a: a, b: b, ctrl: ctrl, rd: rd, rw: rw, br: br, inv: inv, ill: 1'b0};
        return e;
    endfunction

    function automatic exp_t mk_ill(logic [4:0] rd);
        exp_t e;
        e = '{a: 32'h0, b: 32'h0, ctrl: 4'b0010, rd: rd, rw: 1'b0, br: 1'b0, inv: 1'b0, ill: 1'b1};
        return e;
    endfunction

    function automatic vec_t mkv(logic [31:0] instr, logic [31:0] pc, logic [31:0] rs1,
                                 logic [31:0] rs2, exp_t e);
        vec_t v;
        v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.e = e;
        return v;
    endfunction

    function automatic exp_t dut_out();
        return {out_a, out_b, out_alu_control, out_rd, out_reg_write,
                out_is_branch, out_branch_invert, out_illegal};
    endfunction

    function automatic string fmt(exp_t e);
        return $sformatf("a=%h b=%h ctrl=%b rd=%0d rw=%b br=%b inv=%b ill=%b",
                         e.a, e.b, e.ctrl, e.rd, e.rw, e.br, e.inv, e.ill);
    endfunction

    task automatic drive_in(vec_t v);
        in_valid    = 1'b1;
        in_instr    = v.instr;
        in_pc       = v.pc;
        in_rs1_data = v.rs1;
        in_rs2_data = v.rs2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        tests++;
        if (dut_out() !== '0) begin
            fails++; $display("FAIL reset_data: got %s, required all zero", fmt(dut_out()));
        end
        rst = 1'b0;
    endtask

    task automatic test_decode();
        vec_t v[$];
        int   idx = 0;
        exp_t e;
        exp_t got;
        v.push_back(mkv(32'h002081B3, 0, 5, 7, mk(5, 7, 4'b0010, 3, 1, 0, 0)));
        v.push_back(mkv(32'h402081B3, 0, 5, 7, mk(5, 7, 4'b0011, 3, 1, 0, 0)));
        v.push_back(mkv(32'h002091B3, 0, 32'h11, 32'h22, mk(32'h11, 32'h22, 4'b1000, 3, 1, 0, 0)));
        v.push_back(mkv(32'h0020A1B3, 0, 32'h11, 32'h22, mk(32'h11, 32'h22, 4'b0101, 3, 1, 0, 0)));
        v.push_back(mkv(32'h0020B1B3, 0, 32'h11, 32'h22, mk(32'h11, 32'h22, 4'b0100, 3, 1, 0, 0)));
        v.push_back(mkv(32'h0020C1B3, 0, 32'h11, 32'h22, mk(32'h11, 32'h22, 4'b0111, 3, 1, 0, 0)));
        v.push_back(mkv(32'h0020D1B3, 0, 32'h11, 32'h22, mk(32'h11, 32'h22, 4'b1001, 3, 1, 0, 0)));
        v.push_back(mkv(32'h4020D1B3, 0, 32'h11, 32'h22, mk(32'h11, 32'h22, 4'b1010, 3, 1, 0, 0)));
        v.push_back(mkv(32'h0020E1B3, 0, 32'h11, 32'h22, mk(32'h11, 32'h22, 4'b0001, 3, 1, 0, 0)));
        v.push_back(mkv(32'h0020F1B3, 0, 32'h11, 32'h22, mk(32'h11, 32'h22, 4'b0000, 3, 1, 0, 0)));
        v.push_back(mkv(32'h402091B3, 0, 32'h11, 32'h22, mk_ill(3)));
        v.push_back(mkv(32'h022081B3, 0, 32'h11, 32'h22, mk_ill(3)));
        v.push_back(mkv(32'hFFF00093, 0, 0, 32'h22, mk(0, 32'hFFFFFFFF, 4'b0010, 1, 1, 0, 0)));
        v.push_back(mkv(32'h40000093, 0, 32'h11, 32'h22, mk(32'h11, 32'h400, 4'b0010, 1, 1, 0, 0)));
        v.push_back(mkv(32'h40335293, 0, 32'h80000000, 32'h22, mk(32'h80000000, 3, 4'b1010, 5, 1, 0, 0)));
        v.push_back(mkv(32'h0040D093, 0, 32'h11, 32'h22, mk(32'h11, 4, 4'b1001, 1, 1, 0, 0)));
        v.push_back(mkv(32'h8000C093, 0, 32'h11, 32'h22, mk(32'h11, 32'hFFFFF800, 4'b0111, 1, 1, 0, 0)));
        v.push_back(mkv(32'h40009093, 0, 32'h11, 32'h22, mk_ill(1)));
        v.push_back(mkv(32'h0081A203, 0, 32'h11, 32'h22, mk(32'h11, 8, 4'b0010, 4, 1, 0, 0)));
        v.push_back(mkv(32'hFE20AE23, 0, 32'h11, 32'h22, mk(32'h11, 32'hFFFFFFFC, 4'b0010, 28, 0, 0, 0)));
        v.push_back(mkv(32'h00208463, 0, 32'h11, 32'h22, mk(32'h11, 32'h22, 4'b0011, 8, 0, 1, 0)));
        v.push_back(mkv(32'h00209463, 0, 32'h11, 32'h22, mk(32'h11, 32'h22, 4'b0011, 8, 0, 1, 1)));
        v.push_back(mkv(32'h0020C463, 0, 32'h11, 32'h22, mk(32'h11, 32'h22, 4'b0101, 8, 0, 1, 0)));
        v.push_back(mkv(32'h0020D463, 0, 32'h11, 32'h22, mk(32'h11, 32'h22, 4'b0101, 8, 0, 1, 1)));
        v.push_back(mkv(32'h0020E463, 0, 1, 2, mk(1, 2, 4'b0100, 8, 0, 1, 0)));
        v.push_back(mkv(32'h0020F463, 0, 32'h11, 32'h22, mk(32'h11, 32'h22, 4'b0100, 8, 0, 1, 1)));
        v.push_back(mkv(32'h0020A463, 0, 32'h11, 32'h22, mk_ill(8)));
        v.push_back(mkv(32'h12345537, 0, 32'h11, 32'h22, mk(0, 32'h12345000, 4'b0010, 10, 1, 0, 0)));
        v.push_back(mkv(32'h00001297, 32'h200, 32'h11, 32'h22, mk(32'h200, 32'h1000, 4'b0010, 5, 1, 0, 0)));
        v.push_back(mkv(32'h008000EF, 32'h100, 32'h11, 32'h22, mk(32'h100, 4, 4'b0010, 1, 1, 0, 0)));
        v.push_back(mkv(32'h000080E7, 32'h300, 32'h11, 32'h22, mk(32'h300, 4, 4'b0010, 1, 1, 0, 0)));
        v.push_back(mkv(32'h00000000, 32'h400, 32'h11, 32'h22, mk_ill(0)));
        v.push_back(mkv(32'hFFFFFFFF, 32'h404, 32'h11, 32'h22, mk_ill(31)));
        sb.delete();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            if (idx < v.size()) drive_in(v[idx]);
            else                in_valid = 1'b0;
            if (out_valid && out_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL decode_spurious: got %s, required no entry", fmt(dut_out()));
                end else begin
                    e   = sb.pop_front();
                    got = dut_out();
                    if (got !== e) begin
                        fails++; $display("FAIL decode: got %s, required %s", fmt(got), fmt(e));
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(v[idx].e);
                idx++;
            end
            if (idx == v.size() && sb.size() == 0) break;
        end
        tests++;
        if (idx != v.size() || sb.size() != 0) begin
            fails++; $display("FAIL decode_timeout: got %0d sent %0d pending, required %0d sent 0 pending",
                              idx, sb.size(), v.size());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        vec_t v[3];
        exp_t e;
        exp_t got;
        bit   acc3 = 1'b0;
        v[0] = mkv(32'h002081B3, 0, 1, 2, mk(1, 2, 4'b0010, 3, 1, 0, 0));
        v[1] = mkv(32'h402081B3, 0, 3, 4, mk(3, 4, 4'b0011, 3, 1, 0, 0));
        v[2] = mkv(32'h12345537, 0, 5, 6, mk(0, 32'h12345000, 4'b0010, 10, 1, 0, 0));
        sb.delete();
        @(negedge clk);
        out_ready = 1'b0;
        drive_in(v[0]);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_ready_empty: got %b, required 1", in_ready);
        end
        sb.push_back(v[0].e);
        @(negedge clk);
        drive_in(v[1]);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_ready_one: got %b, required 1", in_ready);
        end
        sb.push_back(v[1].e);
        @(negedge clk);
        drive_in(v[2]);
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            fails++; $display("FAIL b2b_full: got in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
        end
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || dut_out() !== sb[0]) begin
            fails++; $display("FAIL b2b_hold: got in_ready=%b %s, required in_ready=0 %s",
                              in_ready, fmt(dut_out()), fmt(sb[0]));
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            if (acc3) in_valid = 1'b0;
            if (c == 1) begin
                tests++;
                if (in_ready !== 1'b1) begin
                    fails++; $display("FAIL b2b_ready_back: got %b, required 1", in_ready);
                end
            end
            if (c < 3) begin
                tests++;
                if (out_valid !== 1'b1) begin
                    fails++; $display("FAIL b2b_gap: got out_valid=%b at cycle %0d, required 1", out_valid, c);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL b2b_spurious: got %s, required no entry", fmt(dut_out()));
                end else begin
                    e   = sb.pop_front();
                    got = dut_out();
                    if (got !== e) begin
                        fails++; $display("FAIL b2b_order: got %s, required %s", fmt(got), fmt(e));
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(v[2].e);
                acc3 = 1'b1;
            end
            if (acc3 && sb.size() == 0) break;
        end
        tests++;
        if (!acc3 || sb.size() != 0) begin
            fails++; $display("FAIL b2b_timeout: got accepted=%b pending=%0d, required 1 0", acc3, sb.size());
        end
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_drained: got out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_kill(bit use_rst);
        vec_t  j1, j2, j3, k;
        exp_t  e;
        string nm;
        nm = use_rst ? "rst" : "flush";
        j1 = mkv(32'h002081B3, 0, 32'hA1, 32'hA2, mk(32'hA1, 32'hA2, 4'b0010, 3, 1, 0, 0));
        j2 = mkv(32'h0020C1B3, 0, 32'hB1, 32'hB2, mk(32'hB1, 32'hB2, 4'b0111, 3, 1, 0, 0));
        j3 = mkv(32'h0020F1B3, 0, 32'hC1, 32'hC2, mk(32'hC1, 32'hC2, 4'b0000, 3, 1, 0, 0));
        k  = mkv(32'h0081A203, 0, 32'h1000, 0, mk(32'h1000, 8, 4'b0010, 4, 1, 0, 0));
        sb.delete();
        @(negedge clk);
        out_ready = 1'b0;
        drive_in(j1);
        @(negedge clk);
        drive_in(j2);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            fails++; $display("FAIL %s_prefill: got in_ready=%b out_valid=%b, required 0 1", nm, in_ready, out_valid);
        end
        drive_in(j3);
        out_ready = 1'b1;
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL %s_clear: got out_valid=%b in_ready=%b, required 0 1", nm, out_valid, in_ready);
        end
        if (use_rst) begin
            tests++;
            if (dut_out() !== '0) begin
                fails++; $display("FAIL rst_zero: got %s, required all zero", fmt(dut_out()));
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0) begin
                fails++; $display("FAIL %s_leak: got out_valid=%b %s, required 0", nm, out_valid, fmt(dut_out()));
            end
        end
        drive_in(k);
        if (in_ready) sb.push_back(k.e);
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (sb.size() == 0 || out_valid !== 1'b1) begin
            fails++; $display("FAIL %s_resume: got out_valid=%b, required 1", nm, out_valid);
        end else begin
            e = sb.pop_front();
            if (dut_out() !== e) begin
                fails++; $display("FAIL %s_resume_data: got %s, required %s", nm, fmt(dut_out()), fmt(e));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_kill(1'b0);
        test_kill(1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Produces operand and control traffic for the RV32I ALU.
- Decodes an RV32I instruction plus its register-file read data into operand a, operand b, and the 4-bit alu_control code the ALU consumes.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer. Sits between register read and execute.

Parameters:
width, 32, datapath width of pc, rs data, operands; instruction is always 32 bits

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous pipeline kill; drops all held and incoming entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry this cycle
in_instr  input  32  RV32I instruction word
in_pc  input  width  instruction address
in_rs1_data  input  width  register rs1 read value
in_rs2_data  input  width  register rs2 read value
out_valid  output  1  decoded entry valid
out_ready  input  1  execute stage accepts entry
out_a  output  width  ALU operand a
out_b  output  width  ALU operand b
out_alu_control  output  4  ALU operation code
out_rd  output  5  destination register index
out_reg_write  output  1  instruction writes rd
out_is_branch  output  1  conditional branch
out_branch_invert  output  1  branch taken when ALU condition false
out_illegal  output  1  unsupported or illegal encoding

Behaviour:
- alu_control codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SLTU, 0101 SLT
  - 0110 NOR (never issued), 0111 XOR, 1000 SLL, 1001 SRL, 1010 SRA
- Decode (combinational on input, registered on accept):
  - OP 0110011: a=rs1, b=rs2.
    - funct3 000: ADD, or SUB when funct7=0100000.
    - funct3 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
    - funct3 101: SRL, or SRA when funct7=0100000.
    - funct3 110 OR, 111 AND.
    - funct7 must be 0000000, or 0100000 only with funct3 000/101; otherwise illegal. This includes M-extension 0000001.
  - OP-IMM 0010011: same mapping, a=rs1, b=sign-extended instr[31:20].
    - funct3 000 is always ADD.
    - Shifts: b = zero-extended instr[24:20].
    - funct7 must be 0000000 (0100000 allowed only for 101 → SRA); otherwise illegal.
  - LOAD 0000011: ADD, a=rs1, b=sext I-imm.
  - STORE 0100011: ADD, a=rs1, b=sext {instr[31:25],instr[11:7]}; reg_write=0.
  - BRANCH 1100011: a=rs1, b=rs2, is_branch=1, reg_write=0.
    - beq/bne: SUB.
    - blt/bge: SLT.
    - bltu/bgeu: SLTU.
    - invert=1 for bne/bge/bgeu.
    - funct3 010/011 illegal.
  - LUI 0110111: ADD, a=0, b={instr[31:12],12'b0}.
  - AUIPC 0010111: ADD, a=pc, b=U-imm.
  - JAL 1101111 and JALR 1100111: ADD, a=pc, b=4 (link value).
  - reg_write=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR. rd=instr[11:7] always.
  - Any other opcode or illegal field: illegal=1, alu_control=0010, a=b=0, reg_write=0, is_branch=0, invert=0.
- Handshake and storage:
  - Main register (drives outputs) plus skid register. in_ready = ~skid_valid (from register, not combinational on out_ready).
  - Accept when in_valid & in_ready. Deliver when out_valid & out_ready.
  - Latency: entry accepted at edge N shows out_valid=1 and decoded fields after edge N.
  - Accept into main when main empty, or main delivering and skid empty. Otherwise accept into skid.
  - Main delivering with skid full: skid moves to main; in_ready returns to 1 next cycle.
  - Order strictly preserved; no entry duplicated or lost.
  - Output fields stable while out_valid & ~out_ready.
  - Simultaneous accept and deliver with empty skid: new entry replaces main; out_valid stays 1.
- flush:
  - Takes priority over all other actions: main_valid and skid_valid clear at the edge, and a same-cycle incoming entry is dropped.
  - out_valid=0 and in_ready=1 the next cycle.
- rst: priority over flush.
  - After reset edge: out_valid=0, in_ready=1.
  - All data outputs 0, out_alu_control=0000.
  - Reset mid-stall discards held entries.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, ctrl=0010, a=5, b=7, rd=3, reg_write=1.
- SUB 0x402081B3 → ctrl=0011. ADDI x1,x0,-1 (0xFFF00093), rs1=0 → ctrl=0010, b=0xFFFFFFFF. SRAI x5,x6,3 (0x40335293) → ctrl=1010, b=3.
- BLTU x1,x2 (0x0020E463) → ctrl=0100, is_branch=1, invert=0, reg_write=0. BNE funct3=001 variant → ctrl=0011, invert=1.
- LUI x10,0x12345 (0x12345537) → a=0, b=0x12345000, rd=10. JAL at pc=0x100 → a=0x100, b=4. Instr 0x00000000 → illegal=1.
- out_ready=0, present I1,I2,I3 back-to-back → I1,I2 accepted, in_ready=0 while I3 held. Raise out_ready → I1,I2,I3 delivered in order, one per cycle.
- With main and skid full, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, dropped entries never appear. Repeat with rst → same, all outputs zero.
